// File: rtl/execute_writeback.sv
// Writeback stage: carries each issued op's destination through the execute
// latency, commits results into a small register file and serves bypassed reads.
module execute_writeback #(
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_REGS       = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int EX_LATENCY     = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_ex,
  input  logic [ADDR_WIDTH-1:0]     dest_in,
  input  logic [1:0]                wb_sel_in,
  input  logic [REGISTER_WIDTH-1:0] aluout,
  input  logic                      carry,
  input  logic [REGISTER_WIDTH-1:0] mem_data_read_in,
  input  logic [ADDR_WIDTH-1:0]     rd_addr1,
  input  logic [ADDR_WIDTH-1:0]     rd_addr2,
  output logic [REGISTER_WIDTH-1:0] rd_data1,
  output logic [REGISTER_WIDTH-1:0] rd_data2,
  output logic                      wb_valid,
  output logic [ADDR_WIDTH-1:0]     wb_dest,
  output logic [REGISTER_WIDTH-1:0] wb_data,
  output logic                      carry_flag,
  output logic [NUM_REGS-1:0]       pending
);

  localparam int LAST = EX_LATENCY - 1;

  logic                      valid_q [EX_LATENCY];
  logic                      valid_d [EX_LATENCY];
  logic [ADDR_WIDTH-1:0]     dest_q  [EX_LATENCY];
  logic [ADDR_WIDTH-1:0]     dest_d  [EX_LATENCY];
  logic [1:0]                sel_q   [EX_LATENCY];
  logic [1:0]                sel_d   [EX_LATENCY];
  logic [REGISTER_WIDTH-1:0] regs_q  [NUM_REGS];
  logic [REGISTER_WIDTH-1:0] regs_d  [NUM_REGS];
  logic                      wb_valid_q, wb_valid_d;
  logic [ADDR_WIDTH-1:0]     wb_dest_q, wb_dest_d;
  logic [REGISTER_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                      carry_q, carry_d;
  logic                      commit;
  logic [REGISTER_WIDTH-1:0] commit_data;

  function automatic logic writes_reg(input logic [1:0] sel);
    return (sel == 2'b01) || (sel == 2'b10);
  endfunction

  // Tag pipeline never stalls: a bubble is simply enable_ex=0 captured.
  always_comb begin
    valid_d[0] = enable_ex;
    dest_d[0]  = dest_in;
    sel_d[0]   = wb_sel_in;
    for (int i = 1; i < EX_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      dest_d[i]  = dest_q[i-1];
      sel_d[i]   = sel_q[i-1];
    end
  end

  assign commit      = valid_q[LAST] && writes_reg(sel_q[LAST]) && (dest_q[LAST] != '0);
  assign commit_data = (sel_q[LAST] == 2'b10) ? mem_data_read_in : aluout;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit) begin
      regs_d[dest_q[LAST]] = commit_data;
    end
    regs_d[0]  = '0;
    wb_valid_d = commit;
    wb_dest_d  = commit ? dest_q[LAST] : wb_dest_q;
    wb_data_d  = commit ? commit_data : wb_data_q;
    carry_d    = (commit && (sel_q[LAST] == 2'b01)) ? carry : carry_q;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < EX_LATENCY; i++) begin
      if (valid_q[i] && writes_reg(sel_q[i])) begin
        pending[dest_q[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  // The current commit is forwarded so the execute stage never sees stale data.
  assign rd_data1 = (rd_addr1 == '0) ? '0 :
                    (commit && (dest_q[LAST] == rd_addr1)) ? commit_data : regs_q[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 :
                    (commit && (dest_q[LAST] == rd_addr2)) ? commit_data : regs_q[rd_addr2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < EX_LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        dest_q[i]  <= '0;
        sel_q[i]   <= '0;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      carry_q    <= 1'b0;
    end else begin
      for (int i = 0; i < EX_LATENCY; i++) begin
        valid_q[i] <= valid_d[i];
        dest_q[i]  <= dest_d[i];
        sel_q[i]   <= sel_d[i];
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      carry_q    <= carry_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_dest    = wb_dest_q;
  assign wb_data    = wb_data_q;
  assign carry_flag = carry_q;

endmodule

// File: doc/execute_writeback.md
Name: execute_writeback

Overview:
- Stage directly downstream of the execute pair (operand preprocessor + ALU).
- Tracks each issued op's destination through the 2-cycle execute latency and commits aluout or mem_data_read_in into an 8-entry register file.
- Provides bypassed operand reads that feed src1/src2 of the execute stage, plus a per-register pending scoreboard for the issue logic.

Parameters:
REGISTER_WIDTH, 32, datapath width
NUM_REGS, 8, register file entries; register 0 hardwired to zero
ADDR_WIDTH, 3, register index width (log2 NUM_REGS)
EX_LATENCY, 2, cycles from enable_ex issue to aluout valid

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
enable_ex  input  1  op issued to execute this cycle (same cycle as preprocessor sees it)
dest_in  input  ADDR_WIDTH  destination register of issued op
wb_sel_in  input  2  00 no write, 01 write aluout, 10 write mem_data_read_in, 11 reserved (no write)
aluout  input  REGISTER_WIDTH  ALU result, signed
carry  input  1  ALU carry
mem_data_read_in  input  REGISTER_WIDTH  load data, valid in commit cycle
rd_addr1  input  ADDR_WIDTH  operand read address 1
rd_addr2  input  ADDR_WIDTH  operand read address 2
rd_data1  output  REGISTER_WIDTH  combinational bypassed read 1
rd_data2  output  REGISTER_WIDTH  combinational bypassed read 2
wb_valid  output  1  registered: a write committed last cycle
wb_dest  output  ADDR_WIDTH  registered committed destination
wb_data  output  REGISTER_WIDTH  registered committed data
carry_flag  output  1  carry of most recent committed ALU write
pending  output  NUM_REGS  bit r set while a write to r is in flight

Behaviour:
- Reset (reset=0, async): tag pipeline valids, register file, wb_valid, wb_dest, wb_data, carry_flag all 0. In-flight ops discarded. pending=0; rd_data returns 0.
- Tag pipeline: EX_LATENCY stages of {valid, dest, sel}.
  - Stage 0 captures {enable_ex, dest_in, wb_sel_in} each edge; enable_ex=0 inserts a bubble.
  - Stages shift every edge; no stall.
- Commit: issue in cycle T -> last stage valid in cycle T+2, aligned with aluout.
  - Commit condition: last stage valid, sel in {01,10}, dest!=0.
  - Commit data: aluout for sel 01, mem_data_read_in for sel 10.
  - Register file written at end of T+2; wb_valid/wb_dest/wb_data show the commit in T+3.
  - wb_valid=0 otherwise, including dest=0 and sel 00/11. wb_dest/wb_data hold their last values when wb_valid=0.
- carry_flag: loads carry on a commit with sel=01; holds otherwise. A sel=01 op to dest 0 does not commit, so it does not update the flag.
- Reads:
  - rd_addr=0 returns 0.
  - Else, if the commit condition holds this cycle and dest==rd_addr, returns the commit data (bypass).
  - Else returns the register file contents.
  - Both ports are independent and may share an address.
- pending[r] = OR over all tag stages of (valid & sel in {01,10} & dest==r), combinational. pending[0] is always 0.
  - Two in-flight ops to the same r keep it set until the last one commits.
- Back-to-back commits to the same register: the later one wins; the bypass always uses the current commit.
- Arithmetic: no transformation; data is stored and forwarded verbatim (two's complement, REGISTER_WIDTH bits).

Test Plan:
- Reset: hold reset=0 mid-stream with 2 ops in flight, release -> no wb_valid for 3 cycles; rd_data1 for r1..r7 = 0; pending=0; carry_flag=0.
- Latency: issue enable_ex=1, dest=3, sel=01 at T; aluout=0x0000_00A5, carry=1 at T+2 -> wb_valid=1, wb_dest=3, wb_data=0xA5 at T+3; carry_flag=1; pending[3]=1 during T+1..T+2 only.
- Bypass: same op, rd_addr1=3 in T+2 -> rd_data1=0xA5 combinationally. rd_addr2=3 in T+3 -> 0xA5 from the register file.
- Load and zero register: sel=10, dest=5, mem_data_read_in=0xFFFF_FFFE -> r5=-2. Op with dest=0, sel=01 -> wb_valid stays 0 and reads of r0 return 0.
- Back-to-back same dest: issue dest=2 at T and T+1 with aluout 7 then 9 -> r2=9. pending[2] high T+1..T+3. Bubble (enable_ex=0) at T+2 -> no commit at T+4.
- Reserved/no-write: sel=11 and sel=00 with carry=1 -> no register change, carry_flag unchanged, pending not set.
